// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_response_checker
// Purpose  : Settle-then-sample checker for a 2-input gate DUT: counts
//            pass/fail, tracks vector coverage, captures the first failure.
//            Define CHK_SYNC_EN to put 2-flop synchronizers on a, b and x.
// Revision : 1.0 - initial release
// ============================================================================
module gate_response_checker #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8,
  parameter int OP     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             x,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov,
  output logic             done,
  output logic             err,
  output logic [2:0]       first_fail_vec
);

  localparam logic [7:0]       c_CNT_LAST = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  logic w_a, w_b, w_x;

`ifdef CHK_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {a, b, x};
      r_sync2 <= r_sync1;
    end
  end

  assign w_a = r_sync2[2];
  assign w_b = r_sync2[1];
  assign w_x = r_sync2[0];
`else
  assign w_a = a;
  assign w_b = b;
  assign w_x = x;
`endif

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [7:0]       r_cnt;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [3:0]       r_cov;
  logic             r_err;
  logic [2:0]       r_ffv;

  logic [1:0] w_vec;
  logic       w_exp;
  logic       w_match;

  assign w_vec = {w_a, w_b};

  always_comb begin
    w_exp = r_vec[1] & r_vec[0];
    case (OP)
      1:       w_exp = r_vec[1] | r_vec[0];
      2:       w_exp = r_vec[1] ^ r_vec[0];
      3:       w_exp = ~(r_vec[1] & r_vec[0]);
      default: w_exp = r_vec[1] & r_vec[0];
    endcase
  end

  assign w_match = (w_x == w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= 2'b00;
      r_cnt   <= 8'd0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_cov   <= 4'h0;
      r_err   <= 1'b0;
      r_ffv   <= 3'b000;
    end else begin
      if (!en) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_vec   <= w_vec;
            r_cnt   <= 8'd0;
            r_state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            // Any input movement restarts the settle window from zero.
            if (w_vec != r_vec) begin
              r_vec <= w_vec;
              r_cnt <= 8'd0;
            end else if (r_cnt == c_CNT_LAST) begin
              r_state <= ST_SAMPLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          ST_SAMPLE: begin
            r_state <= ST_HOLD;
            if (!clr) begin
              if (w_match) begin
                if (r_pass != c_CNT_MAX) r_pass <= r_pass + 1'b1;
              end else begin
                if (r_fail != c_CNT_MAX) r_fail <= r_fail + 1'b1;
                if (!r_err) begin
                  r_err <= 1'b1;
                  r_ffv <= {r_vec, w_x};
                end
              end
              r_cov[r_vec] <= 1'b1;
            end
          end
          default: begin
            if (w_vec != r_vec) begin
              r_vec   <= w_vec;
              r_cnt   <= 8'd0;
              r_state <= ST_SETTLE;
            end
          end
        endcase
      end
      if (clr) begin
        r_pass <= '0;
        r_fail <= '0;
        r_cov  <= 4'h0;
        r_err  <= 1'b0;
        r_ffv  <= 3'b000;
      end
    end
  end

  assign pass_cnt       = r_pass;
  assign fail_cnt       = r_fail;
  assign cov            = r_cov;
  assign done           = (r_cov == 4'hF);
  assign err            = r_err;
  assign first_fail_vec = r_ffv;

endmodule
`default_nettype wire

// File: tb/tb_gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_response_checker
// Purpose  : Directed + randomized bench for gate_response_checker (AND,
//            SETTLE=4) with a run-length reference model; CNT_W=8 and CNT_W=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_response_checker;

  localparam int c_SETTLE = 4;

  logic clk, rst_n, en, clr, a, b, x;
  logic [7:0] pass_cnt, fail_cnt;
  logic [1:0] pass_s, fail_s;
  logic [3:0] cov, cov_s;
  logic       done, err, done_s, err_s;
  logic [2:0] ffv, ffv_s;

  gate_response_checker #(.SETTLE(c_SETTLE), .CNT_W(8), .OP(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .x(x),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .cov(cov), .done(done),
    .err(err), .first_fail_vec(ffv));

  gate_response_checker #(.SETTLE(c_SETTLE), .CNT_W(2), .OP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .x(x),
    .pass_cnt(pass_s), .fail_cnt(fail_s), .cov(cov_s), .done(done_s),
    .err(err_s), .first_fail_vec(ffv_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a vector is sampled once it has been present for
  // SETTLE+1 consecutive edges; the result lands one edge later.
  int         m_prev, m_run, m_pv;
  bit         m_pend, m_sampled;
  int         m_pass, m_fail, m_pass_s, m_fail_s;
  logic [3:0] m_cov;
  bit         m_err;
  logic [2:0] m_ffv;

  function automatic logic gate_and(input int v);
    return logic'((v >> 1) & v & 1);
  endfunction

  function void model_clear();
    m_pass = 0; m_fail = 0; m_pass_s = 0; m_fail_s = 0;
    m_cov = 4'h0; m_err = 0; m_ffv = 3'b000;
  endfunction

  function void model_reset();
    model_clear();
    m_prev = -1; m_run = 0; m_pv = 0; m_pend = 0; m_sampled = 0;
  endfunction

  function void model_commit(input int v, input logic xx);
    if (xx == gate_and(v)) begin
      m_pass   = (m_pass < 255) ? m_pass + 1 : 255;
      m_pass_s = (m_pass_s < 3) ? m_pass_s + 1 : 3;
    end else begin
      m_fail   = (m_fail < 255) ? m_fail + 1 : 255;
      m_fail_s = (m_fail_s < 3) ? m_fail_s + 1 : 3;
      if (!m_err) begin
        m_err = 1;
        m_ffv = {2'(v), xx};
      end
    end
    m_cov[v] = 1'b1;
  endfunction

  function void model_edge(input logic e, input int v, input logic xx, input logic c);
    bit commit_edge;
    commit_edge = 0;
    if (m_pend) begin
      m_pend = 0;
      commit_edge = 1;
      if (e && !c) model_commit(m_pv, xx);
    end
    if (c) model_clear();
    if (!e) begin
      m_prev = -1; m_run = 0; m_sampled = 0;
      return;
    end
    // Input moves during the sampling cycle are noticed one edge later.
    if (commit_edge) return;
    if (v == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_prev = v; m_run = 1; m_sampled = 0;
    end
    if (m_run == c_SETTLE + 1 && !m_sampled) begin
      m_pend = 1; m_pv = v; m_sampled = 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    chk("cov", 32'(cov), 32'(m_cov));
    chk("done", 32'(done), 32'(m_cov == 4'hF));
    chk("err", 32'(err), 32'(m_err));
    chk("first_fail_vec", 32'(ffv), 32'(m_ffv));
    chk("sat_pass_cnt", 32'(pass_s), 32'(m_pass_s));
    chk("sat_fail_cnt", 32'(fail_s), 32'(m_fail_s));
    chk("sat_cov", 32'(cov_s), 32'(m_cov));
    chk("sat_err", 32'(err_s), 32'(m_err));
  endtask

  // Called at a negedge: drive, take one rising edge, then compare.
  task automatic tick(input logic e, input int v, input logic xx, input logic c);
    en = e; a = logic'((v >> 1) & 1); b = logic'(v & 1); x = xx; clr = c;
    @(posedge clk);
    model_edge(e, v, xx, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic hold_vec(input int v, input logic xx, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, v, xx, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vecs[4];
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0; x = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Idle with en low: nothing may move regardless of inputs.
    for (int i = 0; i < 20; i++)
      tick(1'b0, int'($urandom_range(0, 3)), logic'($urandom_range(0, 1)), 1'b0);
    chk("idle_pass", 32'(pass_cnt), 32'd0);

    // Full pass over all four vectors.
    vecs = '{0, 2, 1, 3};
    foreach (vecs[i]) hold_vec(vecs[i], gate_and(vecs[i]), 10);
    chk("full_pass", 32'(pass_cnt), 32'd4);
    chk("full_fail", 32'(fail_cnt), 32'd0);
    chk("full_cov", 32'(cov), 32'hF);
    chk("full_done", 32'(done), 32'd1);
    chk("full_err", 32'(err), 32'd0);
    chk("full_sat_pass", 32'(pass_s), 32'd3);

    // Fault capture.
    do_reset();
    hold_vec(3, 1'b0, 10);
    hold_vec(0, 1'b0, 10);
    chk("fault_fail", 32'(fail_cnt), 32'd1);
    chk("fault_pass", 32'(pass_cnt), 32'd1);
    chk("fault_err", 32'(err), 32'd1);
    chk("fault_ffv", 32'(ffv), 32'b110);

    // Glitch: only the final stable 00 counts, on the 6th edge after the change.
    do_reset();
    hold_vec(0, 1'b0, 2);
    hold_vec(2, 1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 0, 1'b0, 1'b0);
      chk("glitch_timing", 32'(pass_cnt), (i >= 5) ? 32'd1 : 32'd0);
    end
    chk("glitch_cov", 32'(cov), 32'b0001);

    // Saturation on the 2-bit instance, then clear.
    do_reset();
    for (int i = 0; i < 6; i++) hold_vec((i % 2 == 0) ? 0 : 3, gate_and((i % 2 == 0) ? 0 : 3), 10);
    chk("sat_pass", 32'(pass_s), 32'd3);
    chk("sat_wide_pass", 32'(pass_cnt), 32'd6);
    tick(1'b1, 3, 1'b1, 1'b1);
    chk("clr_pass", 32'(pass_cnt), 32'd0);
    chk("clr_cov", 32'(cov), 32'd0);
    chk("clr_sat_pass", 32'(pass_s), 32'd0);

    // Reset two cycles into a settle, then recount after release.
    hold_vec(1, 1'b0, 2);
    do_reset();
    chk("midrst_pass", 32'(pass_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1, 1'b0, 1'b0);
      chk("midrst_timing", 32'(pass_cnt), (i >= c_SETTLE + 1) ? 32'd1 : 32'd0);
    end

    // Randomized segments against the model.
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 30; s++) begin
        int   v, len;
        logic e, xx, c;
        v   = int'($urandom_range(0, 3));
        len = int'($urandom_range(1, 8));
        e   = ($urandom_range(0, 9) != 0);
        xx  = ($urandom_range(0, 3) == 0) ? ~gate_and(v) : gate_and(v);
        c   = ($urandom_range(0, 19) == 0);
        tick(e, v, xx, c);
        for (int k = 1; k < len; k++) tick(e, v, xx, 1'b0);
      end
      tick(1'b1, m_prev < 0 ? 0 : m_prev, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) tick(1'b1, m_prev, gate_and(m_prev), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_response_checker.md
# gate_response_checker

Sequential response checker for the small-gate lab DUTs, such as the 2-input AND gate. It sits opposite the stimulus side: it watches the DUT inputs `a`, `b` and the output `x`, and waits for inputs to be stable for a settle window. It then samples `x` once per stable vector, compares it with the expected gate function, and accumulates pass/fail counts, vector coverage and first-failure capture. It is used in simulation benches and on-board self-test wrappers.

## Interface
Parameters:
- `SETTLE`, 4: cycles the `{a,b}` vector must be stable before `x` is sampled; legal range 1..255.
- `CNT_W`, 8: width of the pass and fail counters.
- `OP`, 0: expected function; 0=AND, 1=OR, 2=XOR, 3=NAND.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: checking enable; low forces IDLE and freezes the counters.
- `clr` in 1: synchronous clear of counters, coverage, `err` and capture; has priority over counting.
- `a`, `b` in 1: DUT inputs, observed only.
- `x` in 1: DUT output under check.
- `pass_cnt` out CNT_W: number of matching samples, saturating.
- `fail_cnt` out CNT_W: number of mismatching samples, saturating.
- `cov` out 4: bit `{a,b}` is set once that vector has been sampled.
- `done` out 1: high when `cov==4'hF`.
- `err` out 1: sticky; set on the first mismatch.
- `first_fail_vec` out 3: `{a,b,x}` captured at the first mismatch.

## Operation
- Registers: `vec_q[1:0]` holds the last `{a,b}`; `cnt` is the settle counter; `state` is the FSM state.
- FSM states and transitions:
  - IDLE: if `en`, load `vec_q<={a,b}`, `cnt<=0`, go to SETTLE.
  - SETTLE:
    - If `{a,b}!=vec_q`: reload `vec_q`, `cnt<=0`, stay in SETTLE (glitch restart).
    - Otherwise, when `cnt==SETTLE-1` go to SAMPLE; else `cnt<=cnt+1`.
  - SAMPLE (exactly one cycle):
    - Compute `exp=f_OP(vec_q)`.
    - If `x==exp`, increment `pass_cnt`; otherwise increment `fail_cnt`.
    - Set `cov[vec_q]`.
    - On the first mismatch, set `err` and load `first_fail_vec<={vec_q,x}`.
    - Go to HOLD.
  - HOLD: wait; when `{a,b}!=vec_q`, reload `vec_q`, `cnt<=0`, go to SETTLE.
- Each stable vector is sampled exactly once. Holding a vector longer never re-counts it; re-applying the same vector after a different one counts again.
- A change of `{a,b}` during SAMPLE does not abort the sample already in progress; it is seen in HOLD on the next cycle.
- `en` low in any state: go to IDLE next cycle, no count, outputs hold.
- Counters saturate at `2^CNT_W-1`; no wrap.
- `err` and `first_fail_vec` change only on the first mismatch after reset or `clr`.
- `clr` together with SAMPLE: the clear wins and the sample is discarded. The FSM still proceeds to HOLD.
- `done` is combinational from `cov`.

## Timing
- Reset values: `pass_cnt=0`, `fail_cnt=0`, `cov=0`, `done=0`, `err=0`, `first_fail_vec=3'b000`; state=IDLE.
- Vector change at edge N is seen by SETTLE at edge N+1. SAMPLE occupies edge N+SETTLE+1; counters are updated at edge N+SETTLE+2.
- `x` is sampled in the SAMPLE cycle only; it must be valid by then.
- Reset asserted mid-operation: all registers return to reset values immediately, and the partial settle is discarded.

## Configuration
- `CHK_SYNC_EN` defined: `a`, `b` and `x` each pass through a 2-flop synchronizer (reset to 0) before the FSM. This adds 2 cycles to every latency above and allows asynchronous board inputs.
- `CHK_SYNC_EN` undefined: inputs are used directly and must be synchronous to `clk`.

## Test plan
All scenarios use the defaults (`OP=0`, `SETTLE=4`) unless noted.
- Reset: hold `rst_n=0` → all outputs are 0. Release and wait 20 cycles with `en=0` → outputs stay 0.
- Full pass: with `en=1`, apply `{a,b}` = 00, 10, 01, 11, each for 10 cycles, with `x=a&b` → `pass_cnt=4`, `fail_cnt=0`, `cov=F`, `done=1`, `err=0`.
- Fault: apply 11 with `x` forced to 0, then 00 with correct `x` → `fail_cnt=1`, `pass_cnt=1`, `err=1`, `first_fail_vec=3'b110`.
- Glitch: 00 → 10 → 00 with changes 2 cycles apart, then hold 00 for 10 cycles.
  - Expected: `pass_cnt=1` and `cov=4'b0001`, i.e. only vector 00 is counted.
  - SAMPLE fires no earlier than 5 cycles after the last change.
- Saturation (`CNT_W=2`): alternate 00/11 for 6 correct stable vectors → `pass_cnt=3`. Pulse `clr` → all outputs 0.
- Reset mid-settle: deassert `rst_n` 2 cycles after a vector change → no count, all outputs 0. After release with `en=1` and `{a,b}` held stable, the vector is counted once, `SETTLE+2` cycles after release.
